// File: rtl/wave_shaper.sv
`default_nettype none
// ============================================================================
// Module   : wave_shaper
// Brief    : 3-stage phase-to-amplitude converter (sine/triangle/saw/square)
//            with period-wrap flag. Optional amplitude scaling is enabled by
//            defining WAVE_AMP_SCALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wave_shaper (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] phase_in,
    input  logic       in_valid,
    input  logic [1:0] wave_sel,
    input  logic [9:0] duty,
`ifdef WAVE_AMP_SCALE_EN
    input  logic [7:0] amp_scale,
`endif
    output logic [9:0] wave_out,
    output logic       out_valid,
    output logic       wrap_pulse
);

    localparam logic [1:0] SEL_SINE     = 2'b00;
    localparam logic [1:0] SEL_TRIANGLE = 2'b01;
    localparam logic [1:0] SEL_SAWTOOTH = 2'b10;
    localparam logic [1:0] SEL_SQUARE   = 2'b11;

    localparam logic [9:0] MID_SCALE  = 10'd512;
    localparam logic [9:0] FULL_SCALE = 10'd1023;

    // ------------------------------------------------------------------
    // Stage 1: input capture and wrap detection
    // ------------------------------------------------------------------
    logic       s1_valid_q;
    logic [9:0] s1_phase_q;
    logic [1:0] s1_sel_q;
    logic [9:0] s1_duty_q;
    logic       s1_wrap_q;
    logic       s1_wrap_d;
    logic [9:0] last_phase_q;
    logic       seen_q;

    // Only valid samples update last_phase, so bubbles never mask a wrap.
    always_comb begin
        s1_wrap_d = in_valid && seen_q && (phase_in < last_phase_q);
    end

    // ------------------------------------------------------------------
    // Stage 2: raw waveform generation
    // ------------------------------------------------------------------
    logic        s2_valid_q;
    logic [9:0]  s2_raw_q;
    logic [9:0]  s2_raw_d;
    logic        s2_wrap_q;

    logic [8:0]  w_sin_p;
    logic [9:0]  w_sin_pc;
    logic [17:0] w_sin_prod;
    logic [10:0] w_sin_shift;
    logic [8:0]  w_sin_y;
    logic [9:0]  w_sine;
    logic [9:0]  w_tri_t;
    logic [9:0]  w_triangle;
    logic [9:0]  w_square;

    // Parabolic half-wave p*(512-p) peaks at 65536, whose >>7 overflows
    // the 9-bit magnitude by one, hence the clamp to 511.
    always_comb begin
        w_sin_p     = s1_phase_q[8:0];
        w_sin_pc    = MID_SCALE - {1'b0, w_sin_p};
        w_sin_prod  = {9'd0, w_sin_p} * {8'd0, w_sin_pc};
        w_sin_shift = 11'(w_sin_prod >> 7);
        w_sin_y     = (w_sin_shift > 11'd511) ? 9'd511 : w_sin_shift[8:0];
        w_sine      = s1_phase_q[9] ? (10'd511 - {1'b0, w_sin_y})
                                    : (MID_SCALE + {1'b0, w_sin_y});

        w_tri_t     = {s1_phase_q[8:0], 1'b0};
        w_triangle  = s1_phase_q[9] ? (FULL_SCALE - w_tri_t) : w_tri_t;

        w_square    = (s1_phase_q < s1_duty_q) ? FULL_SCALE : 10'd0;

        s2_raw_d    = MID_SCALE;
        case (s1_sel_q)
            SEL_SINE:     s2_raw_d = w_sine;
            SEL_TRIANGLE: s2_raw_d = w_triangle;
            SEL_SAWTOOTH: s2_raw_d = s1_phase_q;
            SEL_SQUARE:   s2_raw_d = w_square;
            default:      s2_raw_d = MID_SCALE;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 3: optional scaling and output register
    // ------------------------------------------------------------------
    logic       s3_valid_q;
    logic [9:0] s3_wave_q;
    logic [9:0] s3_wave_d;
    logic       s3_wrap_q;

`ifdef WAVE_AMP_SCALE_EN
    logic [7:0]         s1_amp_q;
    logic [7:0]         s2_amp_q;
    logic signed [10:0] w_dev;
    logic signed [19:0] w_dev_prod;

    // Scale the deviation from mid-scale; the arithmetic shift floors, and
    // with gain < 1 the result can never leave 0..1022.
    always_comb begin
        w_dev      = $signed({1'b0, s2_raw_q}) - 11'sd512;
        w_dev_prod = 20'(w_dev) * 20'($signed({1'b0, s2_amp_q}));
        s3_wave_d  = MID_SCALE + 10'(w_dev_prod >>> 8);
    end
`else
    always_comb begin
        s3_wave_d = s2_raw_q;
    end
`endif

    // ------------------------------------------------------------------
    // Pipeline registers: valids shift every cycle, data loads on valid
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_phase_q   <= 10'd0;
            s1_sel_q     <= SEL_SINE;
            s1_duty_q    <= 10'd0;
            s1_wrap_q    <= 1'b0;
            last_phase_q <= 10'd0;
            seen_q       <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_raw_q     <= MID_SCALE;
            s2_wrap_q    <= 1'b0;
            s3_valid_q   <= 1'b0;
            s3_wave_q    <= MID_SCALE;
            s3_wrap_q    <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            s1_wrap_q  <= s1_wrap_d;
            if (in_valid) begin
                s1_phase_q   <= phase_in;
                s1_sel_q     <= wave_sel;
                s1_duty_q    <= duty;
                last_phase_q <= phase_in;
                seen_q       <= 1'b1;
            end

            s2_valid_q <= s1_valid_q;
            s2_wrap_q  <= s1_valid_q && s1_wrap_q;
            if (s1_valid_q) begin
                s2_raw_q <= s2_raw_d;
            end

            s3_valid_q <= s2_valid_q;
            s3_wrap_q  <= s2_valid_q && s2_wrap_q;
            if (s2_valid_q) begin
                s3_wave_q <= s3_wave_d;
            end
        end
    end

`ifdef WAVE_AMP_SCALE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_amp_q <= 8'd0;
            s2_amp_q <= 8'd0;
        end else begin
            if (in_valid) begin
                s1_amp_q <= amp_scale;
            end
            if (s1_valid_q) begin
                s2_amp_q <= s1_amp_q;
            end
        end
    end
`endif

    assign wave_out   = s3_wave_q;
    assign out_valid  = s3_valid_q;
    assign wrap_pulse = s3_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_shaper.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_shaper
// Brief    : Directed self-checking bench for wave_shaper (both builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_shaper;

    localparam logic [1:0] SIN = 2'b00;
    localparam logic [1:0] TRI = 2'b01;
    localparam logic [1:0] SAW = 2'b10;
    localparam logic [1:0] SQR = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] phase_in;
    logic       in_valid;
    logic [1:0] wave_sel;
    logic [9:0] duty;
    logic [7:0] amp;
    logic [9:0] wave_out;
    logic       out_valid;
    logic       wrap_pulse;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    wave_shaper dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .phase_in   (phase_in),
        .in_valid   (in_valid),
        .wave_sel   (wave_sel),
        .duty       (duty),
`ifdef WAVE_AMP_SCALE_EN
        .amp_scale  (amp),
`endif
        .wave_out   (wave_out),
        .out_valid  (out_valid),
        .wrap_pulse (wrap_pulse)
    );

    // Expected output for an unscaled raw sample at the current gain.
    function automatic logic [9:0] sc(input logic [9:0] r);
`ifdef WAVE_AMP_SCALE_EN
        int d;
        d = int'(r) - 512;
        return 10'(512 + ((d * int'(amp)) >>> 8));
`else
        return r;
`endif
    endfunction

    task automatic tick(input logic v, input logic [1:0] sel,
                        input logic [9:0] ph, input logic [9:0] dt);
        @(negedge clk);
        in_valid = v;
        wave_sel = sel;
        phase_in = ph;
        duty     = dt;
    endtask

    task automatic idle();
        tick(1'b0, SAW, 10'd0, 10'd0);
    endtask

    task automatic chk(input string tag, input logic ev,
                       input logic [9:0] ew, input logic ewr);
        n_total++;
        assert (out_valid === ev) n_pass++;
        else $error("FAIL %s out_valid got %b want %b", tag, out_valid, ev);
        n_total++;
        assert (wave_out === ew) n_pass++;
        else $error("FAIL %s wave_out got %0d want %0d", tag, wave_out, ew);
        n_total++;
        assert (wrap_pulse === ewr) n_pass++;
        else $error("FAIL %s wrap_pulse got %b want %b", tag, wrap_pulse, ewr);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        phase_in = 10'd0;
        wave_sel = SIN;
        duty     = 10'd0;
        amp      = 8'd255;

        repeat (3) @(negedge clk);
        chk("reset", 1'b0, 10'd512, 1'b0);
        reset_n = 1'b1;

        // Continuous stream; each check sees the sample driven 3 ticks earlier.
        tick(1, SIN, 10'd0,    10'd0);
        tick(1, SIN, 10'd256,  10'd0);
        tick(1, SIN, 10'd512,  10'd0);
        tick(1, SIN, 10'd768,  10'd0);
        chk("sin_p0",    1, sc(10'd512),  0);
        tick(1, TRI, 10'd256,  10'd0);
        chk("sin_p256",  1, sc(10'd1023), 0);
        tick(1, TRI, 10'd1023, 10'd0);
        chk("sin_p512",  1, sc(10'd511),  0);
        tick(1, SAW, 10'd700,  10'd0);
        chk("sin_p768",  1, sc(10'd0),    0);
        tick(1, SQR, 10'd100,  10'd512);
        chk("tri_p256",  1, sc(10'd512),  1);
        tick(1, SQR, 10'd600,  10'd512);
        chk("tri_p1023", 1, sc(10'd1),    0);
        tick(1, SAW, 10'd900,  10'd0);
        chk("saw_p700",  1, sc(10'd700),  1);
        tick(1, SAW, 10'd1000, 10'd0);
        chk("sq_p100",   1, sc(10'd1023), 1);
        tick(1, SAW, 10'd76,   10'd0);
        chk("sq_p600",   1, sc(10'd0),    0);
        tick(1, SAW, 10'd176,  10'd0);
        chk("wrap_900",  1, sc(10'd900),  0);
        tick(1, SAW, 10'd500,  10'd0);
        chk("wrap_1000", 1, sc(10'd1000), 0);
        tick(1, SAW, 10'd500,  10'd0);
        chk("wrap_76",   1, sc(10'd76),   1);
        tick(1, SQR, 10'd0,    10'd0);
        chk("wrap_176",  1, sc(10'd176),  0);
        tick(1, SQR, 10'd1022, 10'd1023);
        chk("rep_500a",  1, sc(10'd500),  0);
        tick(1, SQR, 10'd1023, 10'd1023);
        chk("rep_500b",  1, sc(10'd500),  0);
        idle();
        chk("sq_duty0",  1, sc(10'd0),    1);
        idle();
        chk("sq_d1023a", 1, sc(10'd1023), 0);
        idle();
        chk("sq_d1023b", 1, sc(10'd0),    0);
        idle();
        chk("drain_hold", 0, sc(10'd0),   0);

        // Bubbles between valid samples; wrap across the gap still flagged.
        tick(1, SAW, 10'd1000, 10'd0);
        idle();
        idle();
        tick(1, SAW, 10'd20, 10'd0);
        chk("gap_a",     1, sc(10'd1000), 1);
        idle();
        chk("gap_idle1", 0, sc(10'd1000), 0);
        idle();
        chk("gap_idle2", 0, sc(10'd1000), 0);
        idle();
        chk("gap_b",     1, sc(10'd20),   1);

`ifdef WAVE_AMP_SCALE_EN
        amp = 8'd128;
        tick(1, SIN, 10'd256, 10'd0);
        tick(1, SIN, 10'd768, 10'd0);
        idle();
        amp = 8'd0;
        tick(1, SAW, 10'd900, 10'd0);
        chk("amp128_p256", 1, 10'd767, 0);
        idle();
        chk("amp128_p768", 1, 10'd256, 0);
        idle();
        chk("amp_bubble",  0, 10'd256, 0);
        idle();
        chk("amp0_saw900", 1, 10'd512, 0);
        amp = 8'd255;
`endif

        // Reset with three samples in flight.
        tick(1, SAW, 10'd950, 10'd0);
        tick(1, SAW, 10'd960, 10'd0);
        tick(1, SAW, 10'd970, 10'd0);
        idle();
        chk("pre_rst", 1, sc(10'd950), 0);
        #1 reset_n = 1'b0;
        #1 chk("rst_async", 0, 10'd512, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        chk("post_rst0", 0, 10'd512, 0);
        idle();
        chk("post_rst1", 0, 10'd512, 0);
        idle();
        chk("post_rst2", 0, 10'd512, 0);
        tick(1, SAW, 10'd100, 10'd0);
        idle();
        idle();
        idle();
        chk("post_rst_first", 1, sc(10'd100), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
